// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the single write port of the register file between
//            NUM_REQ writeback sources. Round-robin valid/ready arbitration,
//            one registered output stage, illegal-address filtering with a
//            sticky error report, and a committed-write counter.
// Config   : REGWR_ARB_PRIO0_EN - when defined, requester 0 has fixed top
//            priority and its grants do not move the round-robin pointer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter #(
  parameter int NUM_REQ  = 4,   // 2..8 requesters
  parameter int NUM_REGS = 13,  // legal write addresses 0..NUM_REGS-1
  parameter int CNT_W    = 16   // committed-write counter width
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    stall_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*4-1:0]    req_addr_i,
  input  logic [NUM_REQ*16-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rf_write_enable_o,
  output logic [3:0]              rf_write_addr_o,
  output logic [15:0]             rf_write_data_o,
  output logic [2:0]              grant_id_o,
  input  logic                    err_clear_i,
  output logic                    err_bad_addr_o,
  output logic [3:0]              err_addr_o,
  output logic [CNT_W-1:0]        wr_count_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,  // output stage empty
    S_COMMIT = 1'b1   // output stage presenting a write to the RF
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [3:0]       waddr_q, waddr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [3:0]       err_addr_q, err_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]       valid8;
  logic [7:0]       ready8;
  logic             hs;
  logic [2:0]       sel;
  logic [3:0]       idx;
  logic [3:0]       sel_addr;
  logic [15:0]      sel_data;
  logic             sel_legal;

  // Widen the valid vector to 8 so any 3-bit index stays in range.
  always_comb begin
    valid8                = '0;
    valid8[NUM_REQ-1:0]   = req_valid_i;
  end

  // Grant search: first valid requester at or after rr_ptr, wrapping; none while stalled.
  always_comb begin
    hs  = 1'b0;
    sel = '0;
    idx = '0;
    if (!stall_i) begin
`ifdef REGWR_ARB_PRIO0_EN
      if (valid8[0]) begin
        hs  = 1'b1;
        sel = '0;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = {1'b0, rr_ptr_q} + 4'(k);
        if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
        if (!hs && valid8[idx[2:0]]) begin
          hs  = 1'b1;
          sel = idx[2:0];
        end
      end
    end
  end

  // One-hot ready from the selected index; valid is implied, so ready == handshake.
  always_comb begin
    ready8 = '0;
    if (hs) ready8[sel] = 1'b1;
    req_ready_o = ready8[NUM_REQ-1:0];
  end

  // Pick the granted slot's address/data and classify the address.
  always_comb begin
    sel_addr  = req_addr_i[int'(sel)*4 +: 4];
    sel_data  = req_data_i[int'(sel)*16 +: 16];
    sel_legal = ({1'b0, sel_addr} < 5'(NUM_REGS));
  end

  // Next state of the output stage, pointer, error capture and counter.
  always_comb begin
    state_d    = S_IDLE;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;

    if (hs) begin
      grant_id_d = sel;
`ifdef REGWR_ARB_PRIO0_EN
      if (sel != 3'd0)
`endif
        rr_ptr_d = (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
    end

    if (hs && sel_legal) begin
      state_d = S_COMMIT;
      waddr_d = sel_addr;
      wdata_d = sel_data;
      cnt_d   = cnt_q + 1'b1;
    end

    // A new illegal address beats a simultaneous clear.
    if (hs && !sel_legal) begin
      err_d = 1'b1;
      if (!err_q || err_clear_i) err_addr_d = sel_addr;
    end else if (err_clear_i) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
  end

  // State register; async reset drops any pending write before it reaches the RF.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rf_write_enable_o = (state_q == S_COMMIT);
  assign rf_write_addr_o   = waddr_q;
  assign rf_write_data_o   = wdata_q;
  assign grant_id_o        = grant_id_q;
  assign err_bad_addr_o    = err_q;
  assign err_addr_o        = err_addr_q;
  assign wr_count_o        = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed, table-driven bench for regfile_write_arbiter plus
//            hand-written multi-cycle sequences (reset mid-write, round-robin,
//            stall, counter wrap on a narrow-counter instance).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        clr;
  logic [3:0]  valid;
  logic [15:0] addr;
  logic [63:0] data;

  logic [3:0]  ready;
  logic        we;
  logic [3:0]  wa;
  logic [15:0] wd;
  logic [2:0]  gid;
  logic        err;
  logic [3:0]  ea;
  logic [15:0] cnt;

  logic [3:0]  ready_w;
  logic        we_w;
  logic [3:0]  wa_w;
  logic [15:0] wd_w;
  logic [2:0]  gid_w;
  logic        err_w;
  logic [3:0]  ea_w;
  logic [3:0]  cnt_w;

  int checks   = 0;
  int failures = 0;

  regfile_write_arbiter #(.NUM_REQ(4), .NUM_REGS(13), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready), .rf_write_enable_o(we), .rf_write_addr_o(wa),
    .rf_write_data_o(wd), .grant_id_o(gid), .err_clear_i(clr),
    .err_bad_addr_o(err), .err_addr_o(ea), .wr_count_o(cnt)
  );

  regfile_write_arbiter #(.NUM_REQ(4), .NUM_REGS(13), .CNT_W(4)) dut_w (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready_w), .rf_write_enable_o(we_w), .rf_write_addr_o(wa_w),
    .rf_write_data_o(wd_w), .grant_id_o(gid_w), .err_clear_i(clr),
    .err_bad_addr_o(err_w), .err_addr_o(ea_w), .wr_count_o(cnt_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        stall;
    logic        clr;
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [63:0] data;
    logic [3:0]  rdy;
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [2:0]  gid;
    logic        err;
    logic [3:0]  ea;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic s, logic c, logic [3:0] v, logic [15:0] a,
                              logic [63:0] d, logic [3:0] r, logic w,
                              logic [3:0] xa, logic [15:0] xd, logic [2:0] g,
                              logic e, logic [3:0] xe, logic [15:0] n);
    vec_t t;
    t.stall = s; t.clr = c; t.valid = v; t.addr = a; t.data = d;
    t.rdy = r; t.we = w; t.wa = xa; t.wd = xd; t.gid = g;
    t.err = e; t.ea = xe; t.cnt = n;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; clr = 1'b0; valid = '0; addr = '0; data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Stimulus/expectation table, starting from a fresh reset (rr_ptr = 0).
    tbl[0]  = mk(0,0,4'b0100,16'h0300,64'h0000_1234_0000_0000, 4'b0100,1,4'd3, 16'h1234,3'd2,0,4'd0, 16'd1);
    tbl[1]  = mk(0,0,4'b1111,16'h7321,64'hA003_A002_A001_A000, 4'b1000,1,4'd7, 16'hA003,3'd3,0,4'd0, 16'd2);
    tbl[2]  = mk(0,0,4'b1111,16'h7321,64'hA003_A002_A001_A000, 4'b0001,1,4'd1, 16'hA000,3'd0,0,4'd0, 16'd3);
    tbl[3]  = mk(0,0,4'b0000,16'h0000,64'h0,                   4'b0000,0,4'd1, 16'hA000,3'd0,0,4'd0, 16'd3);
    tbl[4]  = mk(1,0,4'b1111,16'h7321,64'hA003_A002_A001_A000, 4'b0000,0,4'd1, 16'hA000,3'd0,0,4'd0, 16'd3);
    tbl[5]  = mk(0,0,4'b0001,16'h000E,64'h0000_0000_0000_7777, 4'b0001,0,4'd1, 16'hA000,3'd0,1,4'd14,16'd3);
    tbl[6]  = mk(0,0,4'b0010,16'h00F0,64'h0000_0000_8888_0000, 4'b0010,0,4'd1, 16'hA000,3'd1,1,4'd14,16'd3);
    tbl[7]  = mk(0,1,4'b0000,16'h0000,64'h0,                   4'b0000,0,4'd1, 16'hA000,3'd1,0,4'd0, 16'd3);
    tbl[8]  = mk(0,0,4'b1000,16'hC000,64'hBEEF_0000_0000_0000, 4'b1000,1,4'd12,16'hBEEF,3'd3,0,4'd0, 16'd4);
    tbl[9]  = mk(0,1,4'b0001,16'h000D,64'h0,                   4'b0001,0,4'd12,16'hBEEF,3'd0,1,4'd13,16'd4);
    tbl[10] = mk(0,0,4'b0011,16'h0050,64'h0000_0000_0002_0001, 4'b0010,1,4'd5, 16'h0002,3'd1,1,4'd13,16'd5);

    // Reset state
    edge1();
    chk("rst_ready", ready, 0);
    chk("rst_we", we, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    chk("rst_gid", gid, 0);
    chk("rst_err", err, 0);
    chk("rst_ea", ea, 0);
    chk("rst_cnt", cnt, 0);
    reset = 1'b0;
    edge1();

    // Reset mid-write: handshake present, reset hits before the capturing edge
    valid = 4'b0010; addr = 16'h0050; data = 64'h0000_0000_BEEF_0000;
    #1;
    chk("midrst_ready", ready, 4'b0010);
    #1 reset = 1'b1;
    edge1();
    chk("midrst_we", we, 0);
    chk("midrst_wa", wa, 0);
    chk("midrst_wd", wd, 0);
    chk("midrst_cnt", cnt, 0);
    idle_inputs();
    edge1();
    reset = 1'b0;
    edge1();
    chk("midrst_we2", we, 0);

    // Table-driven vectors
    do_reset();
    for (int i = 0; i < 11; i++) begin
      stall = tbl[i].stall; clr = tbl[i].clr; valid = tbl[i].valid;
      addr = tbl[i].addr; data = tbl[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), ready, tbl[i].rdy);
      edge1();
      chk($sformatf("v%0d_we", i),  we,  tbl[i].we);
      chk($sformatf("v%0d_wa", i),  wa,  tbl[i].wa);
      chk($sformatf("v%0d_wd", i),  wd,  tbl[i].wd);
      chk($sformatf("v%0d_gid", i), gid, tbl[i].gid);
      chk($sformatf("v%0d_err", i), err, tbl[i].err);
      chk($sformatf("v%0d_ea", i),  ea,  tbl[i].ea);
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
    end
    idle_inputs();

    // Round-robin: all four valid for eight cycles
    do_reset();
    valid = 4'b1111; addr = 16'h4321; data = 64'hD003_D002_D001_D000;
    for (int c = 0; c < 8; c++) begin
      int e;
`ifdef REGWR_ARB_PRIO0_EN
      e = 0;
`else
      e = c % 4;
`endif
      #1;
      chk($sformatf("rr%0d_ready", c), ready, 64'(1) << e);
      edge1();
      chk($sformatf("rr%0d_we", c),  we,  1);
      chk($sformatf("rr%0d_gid", c), gid, e);
      chk($sformatf("rr%0d_wa", c),  wa,  e + 1);
      chk($sformatf("rr%0d_wd", c),  wd,  16'hD000 + 16'(e));
    end
    idle_inputs();
    edge1();
    chk("rr_we_off", we, 0);
    chk("rr_cnt", cnt, 8);

    // Stall blocks grants; release grants req3 and commits next cycle
    do_reset();
    stall = 1'b1; valid = 4'b1000; addr = 16'h9000; data = 64'h5555_0000_0000_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), ready, 0);
      edge1();
      chk($sformatf("stall%0d_we", c), we, 0);
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready", ready, 4'b1000);
    edge1();
    chk("unstall_we", we, 1);
    chk("unstall_wa", wa, 9);
    chk("unstall_wd", wd, 16'h5555);
    // Stall rising while the output stage holds a write
    valid = 4'b0001; addr = 16'h0002; data = 64'h0000_0000_0000_6666;
    edge1();
    stall = 1'b1; valid = 4'b0001;
    #1;
    chk("stallcommit_ready", ready, 0);
    chk("stallcommit_we", we, 1);
    chk("stallcommit_wa", wa, 2);
    edge1();
    chk("stallcommit_we2", we, 0);
    chk("stallcommit_cnt", cnt, 2);

    // Counter wrap on the 4-bit instance: 17 legal writes
    do_reset();
    valid = 4'b0001; addr = 16'h0001; data = 64'h0000_0000_0000_00AA;
    for (int c = 0; c < 17; c++) edge1();
    idle_inputs();
    edge1();
    chk("wrap_cnt4", cnt_w, 1);
    chk("wrap_cnt16", cnt, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
